// File: rtl/lfsr_pkg.sv
// Shared definitions for the PRBS generator / checker pair.
//   chk_state_e : checker FSM states (HUNT, CHECK, LOCKED)
//   POLY8/POLY16: default characteristic polynomial tap masks,
//                 TAPS[k-1]=1 selects term x^k.
package lfsr_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  localparam logic [7:0]  POLY8  = 8'hB8;     // x^8+x^6+x^5+x^4+1
  localparam logic [15:0] POLY16 = 16'hB400;  // x^16+x^14+x^13+x^11+1

endpackage

// File: rtl/lfsr_prbs_checker_if.sv
// Stream/status bundle between the link side and the PRBS checker.
//   master : drives In, In_Valid, Clear; observes Locked, Err, Err_Count
//   slave  : the checker
// Optional macro PRBS_CHK_BIT_COUNT_EN adds Bit_Count (valid bits while locked).
interface lfsr_prbs_checker_if #(
  parameter int unsigned CNT_W = 16
);
  logic             In;
  logic             In_Valid;
  logic             Clear;
  logic             Locked;
  logic             Err;
  logic [CNT_W-1:0] Err_Count;
`ifdef PRBS_CHK_BIT_COUNT_EN
  logic [CNT_W-1:0] Bit_Count;

  modport master (output In, In_Valid, Clear,
                  input  Locked, Err, Err_Count, Bit_Count);
  modport slave  (input  In, In_Valid, Clear,
                  output Locked, Err, Err_Count, Bit_Count);
`else
  modport master (output In, In_Valid, Clear,
                  input  Locked, Err, Err_Count);
  modport slave  (input  In, In_Valid, Clear,
                  output Locked, Err, Err_Count);
`endif
endinterface

// File: rtl/lfsr_predict.sv
// Next-bit predictor: XOR of the history bits selected by TAPS.
//   hist : history, hist[0] = newest bit
//   p    : predicted next bit of the recurrence
module lfsr_predict
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(POLY8)
) (
  input  logic [WIDTH-1:0] hist,
  output logic             p
);

  always_comb p = ^(hist & TAPS);

endmodule

// File: rtl/lfsr_prbs_checker.sv
// Self-synchronising PRBS checker for the Galois LFSR generator stream.
// Ports:
//   Clk, Reset : rising-edge clock, asynchronous active-high reset
//   bus.In / bus.In_Valid : received bit and its qualifier
//   bus.Clear  : synchronous clear of Err_Count (and Bit_Count)
//   bus.Locked : FSM in LOCKED
//   bus.Err    : one-cycle pulse, previous valid bit mismatched while locked
//   bus.Err_Count : saturating error count
// Optional macro PRBS_CHK_BIT_COUNT_EN adds bus.Bit_Count (valid bits while
// locked, saturating) for BER measurement.
module lfsr_prbs_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(POLY8),
  parameter int unsigned      LOCK_CNT = 16,
  parameter int unsigned      LOSS_CNT = 8,
  parameter int unsigned      CNT_W    = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  lfsr_prbs_checker_if.slave   bus
);

  localparam int unsigned FILL_W  = $clog2(WIDTH + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned LOSS_W  = $clog2(LOSS_CNT + 1);

  localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(WIDTH);
  localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(LOCK_CNT);
  localparam logic [LOSS_W-1:0]  LOSS_FULL  = LOSS_W'(LOSS_CNT);

  chk_state_e         state_q, state_d;
  logic [WIDTH-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [LOSS_W-1:0]  loss_q, loss_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   errcnt_q, errcnt_d;
  logic               pred;

  lfsr_predict #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_predict (
    .hist (hist_q),
    .p    (pred)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= HUNT;
      hist_q   <= '0;
      fill_q   <= '0;
      match_q  <= '0;
      loss_q   <= '0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      loss_q   <= loss_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    match_d  = match_q;
    loss_d   = loss_q;
    err_d    = 1'b0;
    errcnt_d = errcnt_q;

    if (bus.In_Valid) begin
      unique case (state_q)
        HUNT: begin
          hist_d = {hist_q[WIDTH-2:0], bus.In};
          // Fill count saturates, so an all-zero history is re-tested on
          // every further bit until a nonzero window appears.
          if (fill_q != FILL_FULL) fill_d = fill_q + 1'b1;
          if (fill_d == FILL_FULL && hist_d != '0) begin
            state_d = CHECK;
            match_d = '0;
          end
        end
        CHECK: begin
          hist_d = {hist_q[WIDTH-2:0], bus.In};
          if (bus.In == pred) begin
            match_d = match_q + 1'b1;
            if (match_d == MATCH_FULL) begin
              state_d = LOCKED;
              loss_d  = '0;
            end
          end else begin
            state_d = HUNT;
            fill_d  = '0;
          end
        end
        LOCKED: begin
          // Flywheel: history follows the prediction, so a line error is
          // not fed back through the taps.
          hist_d = {hist_q[WIDTH-2:0], pred};
          if (bus.In != pred) begin
            err_d = 1'b1;
            if (errcnt_q != '1) errcnt_d = errcnt_q + 1'b1;
            loss_d = loss_q + 1'b1;
            if (loss_d == LOSS_FULL) begin
              state_d = HUNT;
              fill_d  = '0;
            end
          end else begin
            loss_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (bus.Clear) errcnt_d = '0;
  end

  assign bus.Locked    = (state_q == LOCKED);
  assign bus.Err       = err_q;
  assign bus.Err_Count = errcnt_q;

`ifdef PRBS_CHK_BIT_COUNT_EN
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) bitcnt_q <= '0;
    else       bitcnt_q <= bitcnt_d;
  end

  always_comb begin
    bitcnt_d = bitcnt_q;
    if (bus.In_Valid && state_q == LOCKED && bitcnt_q != '1)
      bitcnt_d = bitcnt_q + 1'b1;
    if (bus.Clear) bitcnt_d = '0;
  end

  assign bus.Bit_Count = bitcnt_q;
`endif

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
module tb_lfsr_prbs_checker;

  localparam int         W    = 8;
  localparam logic [7:0] TAPS = 8'hB8;
  localparam int         LOCK = 16;
  localparam int         LOSS = 8;
  localparam int         CW   = 5;
  localparam int         MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  lfsr_prbs_checker_if #(.CNT_W(CW)) bus ();

  lfsr_prbs_checker #(
    .WIDTH    (W),
    .TAPS     (TAPS),
    .LOCK_CNT (LOCK),
    .LOSS_CNT (LOSS),
    .CNT_W    (CW)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  // ---------------- reference stream: s[n] = XOR TAPS-weighted s[n-k]
  bit gq[$];

  function automatic bit parity_of(input bit q[$]);
    int s = 0;
    for (int k = 0; k < W; k++) if (TAPS[k]) s += int'(q[k]);
    return bit'(s % 2);
  endfunction

  function automatic bit gen_next();
    bit b = parity_of(gq);
    gq.push_front(b);
    void'(gq.pop_back());
    return b;
  endfunction

  // ---------------- behavioural checker model
  int m_mode;          // 0 hunting, 1 verifying, 2 locked
  int m_fill, m_match, m_loss, m_cnt, m_bits;
  bit m_err;
  bit mh[$];           // newest at index 0

  function automatic void model_reset();
    m_mode = 0; m_fill = 0; m_match = 0; m_loss = 0;
    m_cnt = 0; m_bits = 0; m_err = 0;
    mh = {};
    for (int i = 0; i < W; i++) mh.push_back(1'b0);
  endfunction

  function automatic void hist_push(input bit b);
    mh.push_front(b);
    void'(mh.pop_back());
  endfunction

  function automatic void model_step(input bit b, input bit v, input bit c);
    bit p = parity_of(mh);
    int old = m_mode;
    m_err = 0;
    if (v) begin
      if (old == 2 && m_bits < MAXC) m_bits++;
      if (old == 0) begin
        hist_push(b);
        if (m_fill < W) m_fill++;
        if (m_fill == W && (mh.sum() with (int'(item))) != 0) begin
          m_mode = 1; m_match = 0;
        end
      end else if (old == 1) begin
        hist_push(b);
        if (b == p) begin
          m_match++;
          if (m_match == LOCK) begin m_mode = 2; m_loss = 0; end
        end else begin
          m_mode = 0; m_fill = 0;
        end
      end else begin
        hist_push(p);
        if (b != p) begin
          m_err = 1;
          if (m_cnt < MAXC) m_cnt++;
          m_loss++;
          if (m_loss == LOSS) begin m_mode = 0; m_fill = 0; end
        end else m_loss = 0;
      end
    end
    if (c) begin m_cnt = 0; m_bits = 0; end
  endfunction

  // ---------------- comparison helper
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("locked", 32'(bus.Locked), 32'(m_mode == 2));
    chk("err", 32'(bus.Err), 32'(m_err));
    chk("err_count", 32'(bus.Err_Count), 32'(m_cnt));
`ifdef PRBS_CHK_BIT_COUNT_EN
    chk("bit_count", 32'(bus.Bit_Count), 32'(m_bits));
`endif
  endtask

  // One clock: called at a negedge, drives inputs, checks after the posedge.
  task automatic cyc(input bit b, input bit v, input bit c);
    bus.In = b; bus.In_Valid = v; bus.Clear = c;
    @(posedge clk); #1;
    model_step(b, v, c);
    chk_model();
    @(negedge clk);
  endtask

  task automatic relock(input string tag);
    for (int i = 1; i <= W + LOCK; i++) begin
      cyc(gen_next(), 1'b1, 1'b0);
      if (i == W + LOCK - 1) chk({tag, "_not_yet"}, 32'(bus.Locked), 32'd0);
      if (i == W + LOCK)     chk({tag, "_locked"}, 32'(bus.Locked), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit g;
    bus.In = 1'b0; bus.In_Valid = 1'b0; bus.Clear = 1'b0;
    do gq = {bit'($urandom), bit'($urandom), bit'($urandom), bit'($urandom),
             bit'($urandom), bit'($urandom), bit'($urandom), bit'($urandom)};
    while ((gq.sum() with (int'(item))) == 0);
    model_reset();

    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst_locked", 32'(bus.Locked), 32'd0);
    chk("rst_err", 32'(bus.Err), 32'd0);
    chk("rst_count", 32'(bus.Err_Count), 32'd0);
    rst = 1'b0;

    // 1: lock after the 24th valid bit, then 1000 clean bits
    relock("lock1");
    for (int i = 0; i < 1000; i++) cyc(gen_next(), 1'b1, 1'b0);
    chk("clean_count", 32'(bus.Err_Count), 32'd0);

    // 2: single inverted bit
    cyc(~gen_next(), 1'b1, 1'b0);
    chk("single_err", 32'(bus.Err), 32'd1);
    chk("single_count", 32'(bus.Err_Count), 32'd1);
    chk("single_locked", 32'(bus.Locked), 32'd1);
    cyc(gen_next(), 1'b1, 1'b0);
    chk("single_err_end", 32'(bus.Err), 32'd0);
    for (int i = 0; i < 40; i++) cyc(gen_next(), 1'b1, 1'b0);
    chk("single_count_hold", 32'(bus.Err_Count), 32'd1);

    // 3: eight consecutive inverted bits lose lock, then re-lock
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= LOSS; i++) begin
      cyc(~gen_next(), 1'b1, 1'b0);
      if (i == LOSS - 1) chk("loss_hold", 32'(bus.Locked), 32'd1);
    end
    chk("loss_dropped", 32'(bus.Locked), 32'd0);
    chk("loss_count", 32'(bus.Err_Count), 32'(LOSS));
    relock("relock");

    // 5: 50% In_Valid while locked, no line errors
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) cyc(gen_next(), 1'b1, 1'b0);
      else                           cyc(bit'($urandom), 1'b0, 1'b0);
    end
    chk("gap_locked", 32'(bus.Locked), 32'd1);

    // mixed: random valid, random errors and bursts, occasional Clear
    for (int i = 0; i < 600; i++) begin
      bit v = ($urandom_range(0, 3) != 0);
      bit c = ($urandom_range(0, 40) == 0);
      if (v) begin
        g = gen_next();
        if ($urandom_range(0, 9) == 0) g = ~g;
        cyc(g, 1'b1, c);
      end else cyc(bit'($urandom), 1'b0, c);
    end

    // make sure we are locked before the saturation test
    if (m_mode != 2) begin
      for (int i = 0; i < 2 * (W + LOCK) && m_mode != 2; i++) cyc(gen_next(), 1'b1, 1'b0);
    end
    chk("presat_locked", 32'(bus.Locked), 32'd1);

    // 6: saturation, Clear priority, reset mid-lock
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < MAXC + 4; i++) begin
      cyc(~gen_next(), 1'b1, 1'b0);
      cyc(gen_next(), 1'b1, 1'b0);
    end
    chk("sat_count", 32'(bus.Err_Count), 32'(MAXC));
    chk("sat_locked", 32'(bus.Locked), 32'd1);
    cyc(~gen_next(), 1'b1, 1'b1);
    chk("clear_prio_count", 32'(bus.Err_Count), 32'd0);
    chk("clear_prio_err", 32'(bus.Err), 32'd1);
    cyc(~gen_next(), 1'b1, 1'b0);
    chk("after_clear_count", 32'(bus.Err_Count), 32'd1);

    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_locked", 32'(bus.Locked), 32'd0);
    chk("midrst_err", 32'(bus.Err), 32'd0);
    chk("midrst_count", 32'(bus.Err_Count), 32'd0);
`ifdef PRBS_CHK_BIT_COUNT_EN
    chk("midrst_bits", 32'(bus.Bit_Count), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    relock("post_rst");

    // 4: all-zero stream after reset never locks
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("zero_locked", 32'(bus.Locked), 32'd0);
    chk("zero_count", 32'(bus.Err_Count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
